// File: rtl/controle_timeout.sv
// controle_timeout: move timer sequencer for an external contador_m.
// Clears the counter at the start of each round, paces its count enable through
// an internal prescaler and watches fim/meio for timeout and half-time alert.
// Consecutive timeouts are counted; MAX_TENT of them lock the block out until
// a new iniciar.
//
// state    | code | meaning
// ---------+------+-----------------------------------------------------
// OCIOSO   |  0   | idle, waiting for iniciar
// PREPARA  |  1   | one cycle: clear counter, prescaler and alerta
// CONTANDO |  2   | timer running, one count pulse every DIV cycles
// PAUSADO  |  3   | timer frozen while pausar is high
// ESTOUROU |  4   | one cycle: timeout pulse, bump tentativas
// ACERTOU  |  5   | one cycle: pronto pulse, clear tentativas
// ESGOTADO |  6   | locked out after MAX_TENT consecutive timeouts
module controle_timeout #(
  parameter int DIV      = 50000,
  parameter int NDIV     = 16,
  parameter int MAX_TENT = 3,
  parameter int NT       = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iniciar,
  input  logic          pausar,
  input  logic          jogada,
  input  logic          cont_fim,
  input  logic          cont_meio,
  output logic          cont_zera_s,
  output logic          cont_conta,
  output logic          alerta,
  output logic          timeout,
  output logic          pronto,
  output logic          esgotado,
  output logic [NT-1:0] tentativas,
  output logic [2:0]    db_estado
);

  localparam logic [2:0] OCIOSO   = 3'd0;
  localparam logic [2:0] PREPARA  = 3'd1;
  localparam logic [2:0] CONTANDO = 3'd2;
  localparam logic [2:0] PAUSADO  = 3'd3;
  localparam logic [2:0] ESTOUROU = 3'd4;
  localparam logic [2:0] ACERTOU  = 3'd5;
  localparam logic [2:0] ESGOTADO = 3'd6;

  localparam logic [NDIV-1:0] PRESC_MAX = NDIV'(DIV - 1);
  localparam logic [NT:0]     TENT_MAX  = (NT+1)'(MAX_TENT);

  logic [2:0]      estado;
  logic [2:0]      proximo;
  logic [NDIV-1:0] prescaler;
  logic            tick;
  logic [NT:0]     tent_inc;

  // Tick marks the last prescaler cycle of a counter period while running.
  assign tick     = (estado == CONTANDO) && (prescaler == PRESC_MAX);
  assign tent_inc = {1'b0, tentativas} + (NT+1)'(1);

  // Next-state decode; in CONTANDO jogada outranks a restart, which outranks
  // an expiring tick, which outranks a pause request.
  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO: begin
        if (iniciar) proximo = PREPARA;
      end
      PREPARA: begin
        proximo = CONTANDO;
      end
      CONTANDO: begin
        if (jogada)                proximo = ACERTOU;
        else if (iniciar)          proximo = PREPARA;
        else if (tick && cont_fim) proximo = ESTOUROU;
        else if (pausar)           proximo = PAUSADO;
      end
      PAUSADO: begin
        if (iniciar)      proximo = PREPARA;
        else if (!pausar) proximo = CONTANDO;
      end
      ESTOUROU: begin
        if (tent_inc == TENT_MAX) proximo = ESGOTADO;
        else                      proximo = PREPARA;
      end
      ACERTOU: begin
        proximo = OCIOSO;
      end
      ESGOTADO: begin
        if (iniciar) proximo = PREPARA;
      end
      default: begin
        proximo = OCIOSO;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) estado <= OCIOSO;
    else       estado <= proximo;
  end

  // Prescaler: cleared on round start, runs only in CONTANDO, holds elsewhere.
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler <= '0;
    end else begin
      case (estado)
        PREPARA: prescaler <= '0;
        CONTANDO: begin
          if (prescaler == PRESC_MAX) prescaler <= '0;
          else                        prescaler <= prescaler + NDIV'(1);
        end
        default: prescaler <= prescaler;
      endcase
    end
  end

  // Consecutive timeout count; any accepted move or a restart from lock-out clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      tentativas <= '0;
    end else begin
      case (estado)
        ESTOUROU: tentativas <= tent_inc[NT-1:0];
        ACERTOU:  tentativas <= '0;
        ESGOTADO: if (iniciar) tentativas <= '0;
        default:  tentativas <= tentativas;
      endcase
    end
  end

  // Half-time alert: set from the counter's meio flag while running, sticky
  // until the next round starts or the block goes idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      alerta <= 1'b0;
    end else begin
      case (estado)
        OCIOSO, PREPARA, ACERTOU: alerta <= 1'b0;
        CONTANDO: if (cont_meio) alerta <= 1'b1;
        default: alerta <= alerta;
      endcase
    end
  end

  // Output decode. cont_zera_s also follows reset so the counter is cleared
  // on the same edge as this block. The count pulse is suppressed when the
  // counter already sits at fim, so the expiring tick never wraps it; fim is
  // itself a registered counter output, so no loop is formed.
  always_comb begin
    cont_zera_s = reset || (estado == PREPARA);
    cont_conta  = tick && !cont_fim;
    timeout     = (estado == ESTOUROU);
    pronto      = (estado == ACERTOU);
    esgotado    = (estado == ESGOTADO);
    db_estado   = estado;
  end

endmodule

// File: tb/tb_controle_timeout.sv
// Bench for controle_timeout with DIV=4, MAX_TENT=2 driving a modulo-8 counter.
module tb_controle_timeout;

  localparam int DIV      = 4;
  localparam int NDIV     = 3;
  localparam int MAX_TENT = 2;
  localparam int NT       = 2;
  localparam int M        = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          iniciar;
  logic          pausar;
  logic          jogada;
  logic          cont_fim;
  logic          cont_meio;
  logic          cont_zera_s;
  logic          cont_conta;
  logic          alerta;
  logic          timeout;
  logic          pronto;
  logic          esgotado;
  logic [NT-1:0] tentativas;
  logic [2:0]    db_estado;
  logic [2:0]    q;

  always #5 clock = ~clock;

  controle_timeout #(
    .DIV(DIV), .NDIV(NDIV), .MAX_TENT(MAX_TENT), .NT(NT)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .pausar(pausar),
    .jogada(jogada), .cont_fim(cont_fim), .cont_meio(cont_meio),
    .cont_zera_s(cont_zera_s), .cont_conta(cont_conta), .alerta(alerta),
    .timeout(timeout), .pronto(pronto), .esgotado(esgotado),
    .tentativas(tentativas), .db_estado(db_estado)
  );

  // contador_m, M=8
  always @(posedge clock) begin
    if (cont_zera_s)     q <= '0;
    else if (cont_conta) q <= (q == 3'(M-1)) ? 3'd0 : q + 3'd1;
  end
  assign cont_fim  = (q == 3'(M-1));
  assign cont_meio = (q == 3'(M/2-1));

  int ciclo = 0;
  always @(posedge clock) ciclo <= ciclo + 1;

  int checks = 0;
  int erros  = 0;

  typedef struct {
    int    ciclo;
    string tag;
    int    esp;
  } esperado_t;

  esperado_t fila[$];

  task automatic verifica(input string tag, input logic [7:0] obs, input logic [7:0] esp);
    checks++;
    if (obs !== esp) begin
      erros++;
      $display("FAIL %s @ciclo %0d: got %0d expected %0d", tag, ciclo, obs, esp);
    end
  endtask

  function automatic logic [7:0] observa(input string tag);
    if (tag == "estado")        return 8'(db_estado);
    else if (tag == "zera")     return 8'(cont_zera_s);
    else if (tag == "conta")    return 8'(cont_conta);
    else if (tag == "alerta")   return 8'(alerta);
    else if (tag == "timeout")  return 8'(timeout);
    else if (tag == "pronto")   return 8'(pronto);
    else if (tag == "esgotado") return 8'(esgotado);
    else if (tag == "tent")     return 8'(tentativas);
    else if (tag == "q")        return 8'(q);
    return 8'hFF;
  endfunction

  task automatic espera(input int c, input string tag, input int v);
    esperado_t e;
    e.ciclo = c;
    e.tag   = tag;
    e.esp   = v;
    fila.push_back(e);
  endtask

  // Scoreboard: compare every expectation due in the current cycle.
  always @(negedge clock) begin
    for (int i = fila.size() - 1; i >= 0; i--) begin
      if (fila[i].ciclo == ciclo) begin
        verifica(fila[i].tag, observa(fila[i].tag), 8'(fila[i].esp));
        fila.delete(i);
      end
    end
  end

  task automatic passo();
    @(posedge clock);
    #1;
  endtask

  task automatic ate(input int c);
    while (ciclo < c) passo();
  endtask

  task automatic inicia(output int k);
    passo();
    iniciar = 1'b1;
    k = ciclo + 1;
    passo();
    iniciar = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, p2, k3, p4, k5, k6;
    reset   = 1'b1;
    iniciar = 1'b0;
    pausar  = 1'b0;
    jogada  = 1'b0;

    ate(2);
    @(negedge clock);
    verifica("rst_zera",   8'(cont_zera_s), 8'd1);
    verifica("rst_estado", 8'(db_estado),   8'd0);
    verifica("rst_tent",   8'(tentativas),  8'd0);
    verifica("rst_conta",  8'(cont_conta),  8'd0);
    verifica("rst_alerta", 8'(alerta),      8'd0);
    verifica("rst_q",      8'(q),           8'd0);
    reset = 1'b0;
    @(negedge clock);
    verifica("idle_zera",   8'(cont_zera_s), 8'd0);
    verifica("idle_estado", 8'(db_estado),   8'd0);

    // Round 1: pacing, alerta, first timeout, automatic restart
    inicia(k);
    espera(k, "estado", 1);     espera(k, "zera", 1);
    espera(k+1, "estado", 2);   espera(k+1, "zera", 0);
    espera(k+3, "conta", 0);    espera(k+4, "conta", 1);
    espera(k+5, "conta", 0);    espera(k+5, "q", 1);
    espera(k+8, "conta", 1);
    espera(k+13, "q", 3);       espera(k+13, "alerta", 0);
    espera(k+14, "alerta", 1);
    espera(k+32, "conta", 0);   espera(k+32, "q", 7);
    espera(k+33, "timeout", 1); espera(k+33, "estado", 4); espera(k+33, "q", 7);
    espera(k+33, "tent", 0);
    espera(k+34, "timeout", 0); espera(k+34, "tent", 1);
    espera(k+34, "estado", 1);  espera(k+34, "zera", 1);
    espera(k+35, "q", 0);       espera(k+35, "estado", 2); espera(k+35, "alerta", 0);
    ate(k+36);

    // Round 2: second timeout locks out
    p2 = k + 34;
    espera(p2+33, "timeout", 1);  espera(p2+33, "estado", 4);
    espera(p2+34, "esgotado", 1); espera(p2+34, "tent", 2);
    espera(p2+34, "estado", 6);   espera(p2+34, "conta", 0);
    espera(p2+40, "esgotado", 1); espera(p2+40, "conta", 0);
    espera(p2+40, "estado", 6);   espera(p2+40, "q", 7);
    ate(p2+41);

    // Round 3: restart from lock-out, one timeout, then jogada at Q=3
    inicia(k3);
    espera(k3, "estado", 1);    espera(k3, "tent", 0);
    espera(k3, "esgotado", 0);  espera(k3, "zera", 1);
    espera(k3+33, "timeout", 1);
    espera(k3+34, "tent", 1);   espera(k3+34, "estado", 1);
    p4 = k3 + 34;
    espera(p4+13, "q", 3);
    espera(p4+15, "pronto", 1); espera(p4+15, "estado", 5); espera(p4+15, "tent", 1);
    espera(p4+16, "pronto", 0); espera(p4+16, "estado", 0);
    espera(p4+16, "tent", 0);   espera(p4+16, "alerta", 0); espera(p4+16, "timeout", 0);
    ate(p4+14);
    jogada = 1'b1;
    passo();
    jogada = 1'b0;
    ate(p4+18);

    // Round 4: jogada coincides with the expiring tick
    inicia(k5);
    espera(k5+29, "q", 7);
    espera(k5+32, "conta", 0);   espera(k5+32, "estado", 2);
    espera(k5+33, "estado", 5);  espera(k5+33, "pronto", 1);
    espera(k5+33, "timeout", 0); espera(k5+33, "q", 7);
    espera(k5+34, "estado", 0);  espera(k5+34, "timeout", 0); espera(k5+34, "tent", 0);
    ate(k5+32);
    jogada = 1'b1;
    passo();
    jogada = 1'b0;
    ate(k5+36);

    // Round 5: pause with prescaler=2, ignored jogada, then reset at Q=5
    inicia(k6);
    for (int i = 3; i <= 12; i++) begin
      espera(k6+i, "estado", 3);
      espera(k6+i, "conta", 0);
    end
    espera(k6+13, "estado", 2); espera(k6+13, "conta", 0);
    espera(k6+14, "conta", 1);
    espera(k6+15, "conta", 0);  espera(k6+15, "q", 1);
    espera(k6+30, "alerta", 1);
    espera(k6+31, "q", 5);      espera(k6+31, "estado", 2); espera(k6+31, "zera", 1);
    espera(k6+32, "estado", 0); espera(k6+32, "q", 0);      espera(k6+32, "zera", 0);
    espera(k6+32, "conta", 0);  espera(k6+32, "alerta", 0); espera(k6+32, "timeout", 0);
    espera(k6+32, "pronto", 0); espera(k6+32, "esgotado", 0); espera(k6+32, "tent", 0);
    ate(k6+2);
    pausar = 1'b1;
    ate(k6+5);
    jogada = 1'b1;
    passo();
    jogada = 1'b0;
    ate(k6+12);
    pausar = 1'b0;
    ate(k6+31);
    reset = 1'b1;
    passo();
    reset = 1'b0;
    ate(k6+34);
    @(negedge clock);
    verifica("pendentes", 8'(fila.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, erros);
    $finish;
  end

endmodule
